// File: rtl/rom_bus_master.sv
// Bus initiator for the 11-bit address / 8-bit tri-state memory bus.
// Sequences single-byte reads and writes with fixed wait states, ready stretching and a watchdog.
module rom_bus_master #(
    parameter int WAIT_STATES = 1,
    parameter int MAX_WAIT    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [10:0] req_addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [10:0] addr,
    inout  wire  [7:0]  data,
    output logic        dataeno,
    output logic        datawe,
    input  logic        ready
);

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

    state_t      state, next_state;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [3:0]  wcnt;
    logic [7:0]  tcnt;
    logic        err_q;
    logic        drive;
    logic        hit;
    logic        abort;

    // Bus strobes decode straight from the state register, so they drop on the
    // same edge that leaves ACCESS (including a reset edge).
    always_comb begin
        // NOTE: every output gets a default before the case; a path that skips an
        // assignment would otherwise infer a latch.
        next_state = state;
        busy       = 1'b1;
        ack        = 1'b0;
        dataeno    = 1'b0;
        datawe     = 1'b0;
        drive      = 1'b0;
        hit        = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) next_state = ADDR;
            end
            ADDR: next_state = ACCESS;
            ACCESS: begin
                dataeno = ~we_q;
                datawe  = we_q;
                drive   = we_q;
                if (wcnt == 4'd0) begin
                    if (ready) begin
                        hit        = 1'b1;
                        next_state = DONE;
                    end else if (tcnt == 8'(MAX_WAIT)) begin
                        abort      = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                ack        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        err = ack & err_q;
    end

    assign data = drive ? wdata_q : 8'hzz;

    // NOTE: state is updated with non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            addr    <= 11'h000;
            rdata   <= 8'h00;
            wcnt    <= 4'd0;
            tcnt    <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        wdata_q <= wdata;
                        addr    <= req_addr;
                    end
                end
                ADDR: begin
                    wcnt  <= 4'(WAIT_STATES);
                    tcnt  <= 8'd0;
                    err_q <= 1'b0;
                end
                ACCESS: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else if (!ready && !abort) begin
                        tcnt <= tcnt + 8'd1;
                    end
                    if (hit && !we_q) rdata <= data;
                    if (abort) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_bus_master.sv
// Directed bench for rom_bus_master: a small bus model answers reads and records writes,
// a negedge monitor watches strobe and data-drive rules, transactions are timed in clocks.
module tb_rom_bus_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [10:0] req_addr;
    logic [7:0]  wdata;
    logic        busy, ack, err, dataeno, datawe;
    logic [7:0]  rdata;
    logic [10:0] addr;
    logic        ready;
    wire  [7:0]  data;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor counters, cleared at the start of each transaction
    int de_cnt, we_cnt, bad_drive, z_viol, both_on;
    logic [7:0]  exp_wdata;
    logic [7:0]  model_rd;
    logic [10:0] wr_addr;
    logic [7:0]  wr_val;

    always #5 clock = ~clock;

    rom_bus_master #(.WAIT_STATES(1), .MAX_WAIT(16)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .req_addr(req_addr),
        .wdata(wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata),
        .addr(addr), .data(data), .dataeno(dataeno), .datawe(datawe), .ready(ready)
    );

    // ROM image: 0x000 holds 3E, low half is addr^5C, upper half unmapped reads 76
    always_comb begin
        if (addr == 11'h000)      model_rd = 8'h3E;
        else if (addr < 11'h400)  model_rd = addr[7:0] ^ 8'h5C;
        else                      model_rd = 8'h76;
    end
    assign data = dataeno ? model_rd : 8'hzz;

    always @(posedge clock) begin
        if (datawe) begin
            wr_addr <= addr;
            wr_val  <= data;
        end
    end

    always @(negedge clock) begin
        if (dataeno) de_cnt++;
        if (datawe) begin
            we_cnt++;
            if (data !== exp_wdata) bad_drive++;
        end
        if (!dataeno && !datawe && data !== 8'hzz) z_viol++;
        if (dataeno && datawe) both_on++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request and returns the clocks from the accepting edge (counted as 1)
    // to the first cycle with ack high. ready is forced high once 'hold' clocks have
    // elapsed; a second req pulse is injected at clock 'extra_at' (0 = none).
    task automatic run_txn(input logic w, input logic [10:0] a, input logic [7:0] d,
                           input int hold, input int extra_at,
                           output int clocks, output logic got_err);
        @(negedge clock);
        check("idle_before_req", busy, 1'b0);
        de_cnt = 0; we_cnt = 0; bad_drive = 0; z_viol = 0; both_on = 0;
        exp_wdata = d;
        req = 1'b1; we = w; req_addr = a; wdata = d;
        ready = (hold == 0);
        @(negedge clock);
        req = 1'b0;
        clocks = 1;
        while (!ack && clocks < 100) begin
            @(negedge clock);
            clocks++;
            req = (clocks == extra_at);
            if (clocks >= hold) ready = 1'b1;
        end
        req = 1'b0;
        got_err = err;
        if (!ack) check("ack_timeout", 32'd0, 32'd1);
        ready = 1'b1;
    endtask

    int   clk_n;
    logic e;

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; req_addr = '0; wdata = '0; ready = 1'b1;
        exp_wdata = '0; de_cnt = 0; we_cnt = 0; bad_drive = 0; z_viol = 0; both_on = 0;
        repeat (2) @(negedge clock);
        check("rst_busy",    busy, 1'b0);
        check("rst_ack",     ack, 1'b0);
        check("rst_err",     err, 1'b0);
        check("rst_dataeno", dataeno, 1'b0);
        check("rst_datawe",  datawe, 1'b0);
        check("rst_addr",    addr, 11'h000);
        check("rst_rdata",   rdata, 8'h00);
        check("rst_data_z",  (data === 8'hzz), 1'b1);
        reset = 1'b0;

        // 1: read 0x000
        run_txn(1'b0, 11'h000, 8'h00, 0, 0, clk_n, e);
        check("t1_latency", clk_n, 4);
        check("t1_err", e, 1'b0);
        check("t1_rdata", rdata, 8'h3E);

        // 2: read unmapped 0x5A0, back-to-back with the previous one
        run_txn(1'b0, 11'h5A0, 8'h00, 0, 0, clk_n, e);
        check("t2_latency", clk_n, 4);
        check("t2_rdata", rdata, 8'h76);
        check("t2_dataeno_cycles", de_cnt, 2);
        check("t2_err", e, 1'b0);

        // 3: write A5 to 0x7FF
        run_txn(1'b1, 11'h7FF, 8'hA5, 0, 0, clk_n, e);
        check("t3_latency", clk_n, 4);
        check("t3_datawe_cycles", we_cnt, 2);
        check("t3_drive_value", bad_drive, 0);
        check("t3_dataeno_cycles", de_cnt, 0);
        check("t3_rdata_kept", rdata, 8'h76);
        check("t3_mem_addr", wr_addr, 11'h7FF);
        check("t3_mem_val", wr_val, 8'hA5);
        @(negedge clock);
        check("t3_addr_hold", addr, 11'h7FF);
        check("t3_data_z_idle", (data === 8'hzz), 1'b1);

        // 4: read 0x123 with ready low for 3 cycles at wcnt=0 (0x23^0x5C = 0x7F)
        run_txn(1'b0, 11'h123, 8'h00, 6, 0, clk_n, e);
        check("t4_latency", clk_n, 7);
        check("t4_rdata", rdata, 8'h7F);
        check("t4_err", e, 1'b0);

        // 5: ready stuck low -> watchdog abort; extra req mid-cycle must be lost
        run_txn(1'b0, 11'h000, 8'h00, 1000, 8, clk_n, e);
        check("t5_latency", clk_n, 20);
        check("t5_err", e, 1'b1);
        check("t5_rdata_kept", rdata, 8'h7F);
        repeat (2) @(negedge clock);
        check("t5_extra_req_lost", busy, 1'b0);
        check("t5_err_low_without_ack", err, 1'b0);

        // 6: reset during ACCESS of a write
        @(negedge clock);
        exp_wdata = 8'h5A;
        req = 1'b1; we = 1'b1; req_addr = 11'h100; wdata = 8'h5A;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        check("t6_in_access", datawe, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("t6_datawe", datawe, 1'b0);
        check("t6_data_z", (data === 8'hzz), 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_addr", addr, 11'h000);
        reset = 1'b0;
        @(negedge clock);
        check("t6_stays_idle", busy, 1'b0);

        check("mon_data_z", z_viol, 0);
        check("mon_strobe_overlap", both_on, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
